// File: rtl/ppfifo_pattern_src_pkg.sv
// Shared definitions for the ping-pong FIFO pattern source: FSM encoding,
// pattern mode codes and the maximal-length LFSR tap table.
package ppfifo_pattern_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] MODE_BURST = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_SEED  = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  localparam int unsigned WORD_CNT_W = 32;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] tap(int unsigned t);
    return 64'(1) << (t - 1);
  endfunction

  // Fibonacci feedback mask; taps are 1-based bit positions of a maximal polynomial
  function automatic logic [63:0] lfsr_taps(int unsigned width);
    logic [63:0] m;
    m = '0;
    case (width)
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      33: m = tap(33) | tap(20);
      34: m = tap(34) | tap(27) | tap(2)  | tap(1);
      35: m = tap(35) | tap(33);
      36: m = tap(36) | tap(25);
      37: m = tap(37) | tap(5)  | tap(4)  | tap(3) | tap(2) | tap(1);
      38: m = tap(38) | tap(6)  | tap(5)  | tap(1);
      39: m = tap(39) | tap(35);
      40: m = tap(40) | tap(38) | tap(21) | tap(19);
      41: m = tap(41) | tap(38);
      42: m = tap(42) | tap(41) | tap(20) | tap(19);
      43: m = tap(43) | tap(42) | tap(38) | tap(37);
      44: m = tap(44) | tap(43) | tap(18) | tap(17);
      45: m = tap(45) | tap(44) | tap(42) | tap(41);
      46: m = tap(46) | tap(45) | tap(26) | tap(25);
      47: m = tap(47) | tap(42);
      48: m = tap(48) | tap(47) | tap(21) | tap(20);
      49: m = tap(49) | tap(40);
      50: m = tap(50) | tap(49) | tap(24) | tap(23);
      51: m = tap(51) | tap(50) | tap(36) | tap(35);
      52: m = tap(52) | tap(49);
      53: m = tap(53) | tap(52) | tap(38) | tap(37);
      54: m = tap(54) | tap(53) | tap(18) | tap(17);
      55: m = tap(55) | tap(31);
      56: m = tap(56) | tap(55) | tap(35) | tap(34);
      57: m = tap(57) | tap(50);
      58: m = tap(58) | tap(39);
      59: m = tap(59) | tap(58) | tap(38) | tap(37);
      60: m = tap(60) | tap(59);
      61: m = tap(61) | tap(60) | tap(46) | tap(45);
      62: m = tap(62) | tap(61) | tap(6)  | tap(5);
      63: m = tap(63) | tap(62);
      default: m = tap(64) | tap(63) | tap(61) | tap(60);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ppfifo_pattern_src_rr.sv
// Round-robin channel selector: first ready channel strictly after the last
// granted index, wrapping at NUM_CH.
module rr_ch_select
  import ppfifo_pattern_src_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]              ready,
  input  logic [idx_width(NUM_CH)-1:0]   last,
  output logic [NUM_CH-1:0]              grant_c,
  output logic [idx_width(NUM_CH)-1:0]   index_c,
  output logic                           found_c
);

  localparam int unsigned IDX_W = idx_width(NUM_CH);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant_c = '0;
    index_c = '0;
    found_c = 1'b0;
    pos     = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      pos = IDX_W'((32'(last) + k) % NUM_CH);
      if (!found_c && ready[pos]) begin
        found_c      = 1'b1;
        grant_c[pos] = 1'b1;
        index_c      = pos;
      end
    end
  end

endmodule

// File: rtl/ppfifo_pattern_src.sv
// Pattern generator that claims one ready FIFO channel at a time and writes a
// burst of test words into it. Define PPFIFO_PATTERN_SRC_LFSR_EN for LFSR mode 3.
module ppfifo_pattern_src
  import ppfifo_pattern_src_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned SIZE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [31:0]           total,
  input  logic [NUM_CH-1:0]     ready,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic [NUM_CH-1:0]     activate,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  strobe,
  output logic                  done,
  output logic [31:0]           words_sent
);

  localparam int unsigned IDX_W = idx_width(NUM_CH);

  state_t                state_q, state_next;
  logic [NUM_CH-1:0]     activate_next;
  logic [DATA_WIDTH-1:0] data_next;
  logic                  strobe_next;
  logic                  done_next;
  logic [WORD_CNT_W-1:0] ws_next;
  logic [SIZE_WIDTH-1:0] cnt_q, cnt_next;
  logic [SIZE_WIDTH-1:0] size_q, size_next;
  logic [1:0]            mode_q, mode_next;
  logic [IDX_W-1:0]      last_q, last_next;
  logic [NUM_CH-1:0]     grant_c;
  logic [IDX_W-1:0]      index_c;
  logic                  found_c;
  logic                  grant_ok;
  logic                  limit_hit;
  logic [DATA_WIDTH-1:0] pattern;
  logic [DATA_WIDTH-1:0] mode3_data;

  rr_ch_select #(
    .NUM_CH(NUM_CH)
  ) u_rr (
    .ready   (ready),
    .last    (last_q),
    .grant_c (grant_c),
    .index_c (index_c),
    .found_c (found_c)
  );

  assign limit_hit = (total != '0) && (words_sent == total);

`ifdef PPFIFO_PATTERN_SRC_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] lfsr_q;
  logic                  lfsr_load;
  logic                  lfsr_step;

  // Sequence restarts only when the running count is at zero, otherwise it continues
  assign lfsr_load = grant_ok && (mode == MODE_LFSR) && (words_sent == '0);
  assign lfsr_step = strobe_next && (mode_q == MODE_LFSR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= DATA_WIDTH'(1);
    end else if (lfsr_load) begin
      lfsr_q <= (seed == '0) ? DATA_WIDTH'(1) : seed;
    end else if (lfsr_step) begin
      lfsr_q <= {lfsr_q[DATA_WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  end

  assign mode3_data = lfsr_q;
`else
  assign mode3_data = DATA_WIDTH'(words_sent);
`endif

  // Word for the next strobe, chosen by the mode latched at grant
  always_comb begin
    pattern = seed;
    case (mode_q)
      MODE_BURST: pattern = DATA_WIDTH'(cnt_q);
      MODE_RUN:   pattern = DATA_WIDTH'(words_sent);
      MODE_SEED:  pattern = seed;
      default:    pattern = mode3_data;
    endcase
  end

  always_comb begin
    state_next    = state_q;
    activate_next = activate;
    data_next     = data;
    strobe_next   = 1'b0;
    done_next     = done;
    ws_next       = words_sent;
    cnt_next      = cnt_q;
    size_next     = size_q;
    mode_next     = mode_q;
    last_next     = last_q;
    grant_ok      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && found_c && (activate == '0) && !done) begin
          grant_ok      = 1'b1;
          activate_next = grant_c;
          last_next     = index_c;
          size_next     = size;
          mode_next     = mode;
          cnt_next      = '0;
          state_next    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Word limit wins over a burst that would also end this cycle
        if (limit_hit) begin
          activate_next = '0;
          done_next     = 1'b1;
          state_next    = ST_DONE;
        end else if (cnt_q == size_q) begin
          activate_next = '0;
          state_next    = ST_RELEASE;
        end else begin
          strobe_next = 1'b1;
          data_next   = pattern;
          cnt_next    = cnt_q + 1'b1;
          ws_next     = words_sent + 32'd1;
        end
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      ST_DONE: begin
        if (!enable) begin
          done_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      activate   <= '0;
      data       <= '0;
      strobe     <= 1'b0;
      done       <= 1'b0;
      words_sent <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      mode_q     <= MODE_BURST;
      last_q     <= IDX_W'(NUM_CH - 1);
    end else begin
      state_q    <= state_next;
      activate   <= activate_next;
      data       <= data_next;
      strobe     <= strobe_next;
      done       <= done_next;
      words_sent <= ws_next;
      cnt_q      <= cnt_next;
      size_q     <= size_next;
      mode_q     <= mode_next;
      last_q     <= last_next;
    end
  end

endmodule

// File: tb/tb_ppfifo_pattern_src.sv
// Directed bench for ppfifo_pattern_src (DATA_WIDTH 8, two channels); follows
// PPFIFO_PATTERN_SRC_LFSR_EN to choose the mode 3 expectations.
module tb_ppfifo_pattern_src;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] seed;
  logic [31:0] total;
  logic [1:0] ready;
  logic [7:0] size;
  logic [1:0] activate;
  logic [7:0] data;
  logic       strobe;
  logic       done;
  logic [31:0] words_sent;

  int checks   = 0;
  int failures = 0;

  logic [1:0] act_seen;
  int         nstb;
  int         ncyc;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  ppfifo_pattern_src #(
    .DATA_WIDTH(8),
    .NUM_CH    (2),
    .SIZE_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .seed       (seed),
    .total      (total),
    .ready      (ready),
    .size       (size),
    .activate   (activate),
    .data       (data),
    .strobe     (strobe),
    .done       (done),
    .words_sent (words_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // Wait for a grant, then record every strobed word until activate drops
  task automatic capture(input bit perturb);
    int w;
    act_seen = '0;
    nstb     = 0;
    ncyc     = 0;
    got.delete();
    w = 0;
    while (activate == '0 && w < 40) begin
      cyc();
      w++;
    end
    act_seen = activate;
    while (activate != '0 && ncyc < 300) begin
      ncyc++;
      if (strobe) begin
        got.push_back(data);
        nstb++;
        if (perturb && nstb == 1) begin
          enable = 1'b0;
          size   = 8'd9;
          mode   = 2'd2;
          ready  = 2'b10;
        end
      end
      cyc();
    end
  endtask

  task automatic check_burst(input string tag, input logic [1:0] ea);
    chk({tag, "_act"}, 32'(act_seen), 32'(ea));
    chk({tag, "_nstb"}, 32'(nstb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_d%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int cnt;
    rst    = 1'b1;
    enable = 1'b0;
    mode   = 2'd0;
    seed   = 8'h00;
    total  = 32'd0;
    ready  = 2'b00;
    size   = 8'd0;
    cyc();
    cyc();
    chk("rst_activate", 32'(activate), 32'd0);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words", words_sent, 32'd0);
    rst = 1'b0;
    cyc();

    // Single channel burst, per-burst count pattern
    ready = 2'b01; size = 8'd4; mode = 2'd0; enable = 1'b1;
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    capture(1'b0);
    enable = 1'b0;
    check_burst("b4", 2'b01);
    chk("b4_ncyc", 32'(ncyc), 32'd5);
    chk("b4_words", words_sent, 32'd4);

    // Round-robin with both channels ready
    do_reset();
    ready = 2'b11; size = 8'd2; mode = 2'd0; enable = 1'b1;
    exp_q = '{8'd0, 8'd1};
    capture(1'b0);
    check_burst("rr0", 2'b01);
    capture(1'b0);
    check_burst("rr1", 2'b10);
    capture(1'b0);
    enable = 1'b0;
    check_burst("rr2", 2'b01);

    // Running count across bursts; second burst perturbed after its first word
    do_reset();
    ready = 2'b01; size = 8'd3; mode = 2'd1; enable = 1'b1;
    exp_q = '{8'd0, 8'd1, 8'd2};
    capture(1'b0);
    check_burst("run0", 2'b01);
    exp_q = '{8'd3, 8'd4, 8'd5};
    capture(1'b1);
    check_burst("run1", 2'b01);
    chk("run_words", words_sent, 32'd6);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (activate != '0) cnt++;
    end
    chk("run_nogrant", 32'(cnt), 32'd0);

    // Word limit truncates the second burst and latches done
    do_reset();
    ready = 2'b01; size = 8'd4; mode = 2'd0; total = 32'd5; enable = 1'b1;
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    capture(1'b0);
    check_burst("lim0", 2'b01);
    exp_q = '{8'd0};
    capture(1'b0);
    check_burst("lim1", 2'b01);
    chk("lim_done", 32'(done), 32'd1);
    chk("lim_words", words_sent, 32'd5);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (activate != '0) cnt++;
    end
    chk("lim_nogrant", 32'(cnt), 32'd0);
    chk("lim_done_hold", 32'(done), 32'd1);
    total  = 32'd0;
    enable = 1'b0;
    cyc();
    chk("lim_done_clr", 32'(done), 32'd0);
    chk("lim_words_keep", words_sent, 32'd5);
    size = 8'd1; mode = 2'd1; enable = 1'b1;
    exp_q = '{8'd5};
    capture(1'b0);
    enable = 1'b0;
    check_burst("lim_after", 2'b01);

    // Zero-size grant: one activate cycle, no strobes
    cyc();
    size = 8'd0; mode = 2'd0; enable = 1'b1;
    exp_q.delete();
    capture(1'b0);
    enable = 1'b0;
    check_burst("sz0", 2'b01);
    chk("sz0_ncyc", 32'(ncyc), 32'd1);

    // Constant seed pattern
    cyc();
    cyc();
    size = 8'd2; mode = 2'd2; seed = 8'h5A; enable = 1'b1;
    exp_q = '{8'h5A, 8'h5A};
    capture(1'b0);
    enable = 1'b0;
    check_burst("seed", 2'b01);

    // Asynchronous reset in the middle of a burst
    do_reset();
    size = 8'd4; mode = 2'd0; ready = 2'b01; enable = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 2; i++) begin
      cyc();
      if (strobe) cnt++;
    end
    chk("mid_reach_w2", 32'(cnt), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_act", 32'(activate), 32'd0);
    chk("mid_strobe", 32'(strobe), 32'd0);
    chk("mid_data", 32'(data), 32'd0);
    chk("mid_words", words_sent, 32'd0);
    cyc();
    chk("mid_act_edge", 32'(activate), 32'd0);
    chk("mid_strobe_edge", 32'(strobe), 32'd0);
    rst    = 1'b0;
    enable = 1'b0;
    cyc();

    // Mode 3 from seed 1, two consecutive bursts
    do_reset();
    mode = 2'd3; seed = 8'h01; size = 8'd4; ready = 2'b01; enable = 1'b1;
`ifdef PPFIFO_PATTERN_SRC_LFSR_EN
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08};
`else
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
`endif
    capture(1'b0);
    check_burst("m3a", 2'b01);
`ifdef PPFIFO_PATTERN_SRC_LFSR_EN
    exp_q = '{8'h11, 8'h23, 8'h47, 8'h8E};
`else
    exp_q = '{8'd4, 8'd5, 8'd6, 8'd7};
`endif
    capture(1'b0);
    enable = 1'b0;
    check_burst("m3b", 2'b01);
    chk("m3_words", words_sent, 32'd8);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppfifo_pattern_src.md
PPFIFO_PATTERN_SRC -- requirements
Module: ppfifo_pattern_src

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width (8..64).
REQ-002 SHALL have parameter NUM_CH, default 2, FIFO channel count (1..8).
REQ-003 SHALL have parameter SIZE_WIDTH, default 24, burst size width.
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port enable  in  1  permits new channel grants.
REQ-007 SHALL have port mode  in  2  pattern: 0 per-burst count, 1 running count, 2 constant seed, 3 LFSR.
REQ-008 SHALL have port seed  in  DATA_WIDTH  constant value / LFSR seed.
REQ-009 SHALL have port total  in  32  word limit, 0 = unlimited.
REQ-010 SHALL have port ready  in  NUM_CH  per-channel FIFO ready.
REQ-011 SHALL have port size  in  SIZE_WIDTH  words available in granted FIFO.
REQ-012 SHALL have port activate  out  NUM_CH  one-hot channel ownership.
REQ-013 SHALL have port data  out  DATA_WIDTH  write data, valid with strobe.
REQ-014 SHALL have port strobe  out  1  one-cycle write pulse per word.
REQ-015 SHALL have port done  out  1  total limit reached.
REQ-016 SHALL have port words_sent  out  32  total strobes since reset.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, RELEASE, DONE.
REQ-018 IDLE: when enable && ready!=0 && activate==0 && !done, SHALL assert exactly one activate bit next cycle, latch size, clear burst count, go STREAM.
REQ-019 Channel choice SHALL be round-robin: first ready channel searching upward (with wrap) from last granted index + 1; after reset search starts at channel 0.
REQ-020 STREAM: while count < latched size, SHALL assert strobe for one cycle per word with data valid in the same cycle, one word per clock, no gaps.
REQ-021 When count == latched size, SHALL deassert activate next cycle (RELEASE), then return to IDLE; a new grant SHALL NOT occur in RELEASE cycle.
REQ-022 size==0 at grant SHALL produce one activate cycle, zero strobes, then release.
REQ-023 Deasserting enable mid-burst SHALL NOT truncate the burst; only new grants are blocked.
REQ-024 Changes to size, ready or mode after grant SHALL NOT affect the current burst.
REQ-025 Mode 0 data SHALL equal burst index (0..size-1), zero-extended/truncated to DATA_WIDTH.
REQ-026 Mode 1 data SHALL equal words_sent value before increment, truncated to DATA_WIDTH, continuing across bursts.
REQ-027 Mode 2 data SHALL equal seed.
REQ-028 words_sent SHALL increment by 1 on each strobe, wrapping modulo 2^32.
REQ-029 When total!=0 and words_sent reaches total, SHALL end the burst at that word (truncated), release activate, enter DONE, assert done.
REQ-030 DONE: done SHALL stay high until enable is low for one cycle, then clear and return to IDLE; words_sent SHALL NOT clear.

Reset
REQ-031 On rst SHALL set activate=0, data=0, strobe=0, done=0, words_sent=0, state IDLE, round-robin pointer to channel NUM_CH-1.
REQ-032 rst mid-burst SHALL drop activate and strobe immediately (asynchronously), no partial word.

Configuration
REQ-033 With PPFIFO_PATTERN_SRC_LFSR_EN defined, mode 3 SHALL output a Fibonacci LFSR (maximal taps per DATA_WIDTH) loaded from seed at grant in IDLE when running count is 0 and advanced once per strobe; seed==0 SHALL be replaced by 1.
REQ-034 Without PPFIFO_PATTERN_SRC_LFSR_EN, mode 3 SHALL behave exactly as mode 1 and no LFSR logic SHALL be synthesised.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding, mode constants, and LFSR tap table.
REQ-036 Round-robin arbiter SHALL be a sub-module rr_ch_select (NUM_CH in, one-hot + index out).

Verification
REQ-037 ready=2'b01, size=4, mode 0 -> activate=01, 4 strobes data 0,1,2,3, then activate=00.
REQ-038 ready=2'b11 held, size=2, three bursts -> grants alternate ch0, ch1, ch0.
REQ-039 mode 1, two bursts size=3 -> data 0..5, words_sent=6.
REQ-040 total=5, size=4 -> bursts of 4 then 1, done=1, no further activate until enable toggled low.
REQ-041 size=0 -> one activate cycle, zero strobes; rst mid-burst at word 2 -> all outputs 0 next edge.
REQ-042 LFSR_EN defined, mode 3, seed 1, DATA_WIDTH 8 -> first 4 data match reference LFSR model; undefined -> matches mode 1.
